// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the mod_counter timing/event-count primitive.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FREE    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/ce_prescaler.sv
// Clock-enable prescaler: emits one tick every PRESCALE cycles on which run=1.
// The phase holds while run=0 and is zeroed by restart.
module ce_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // Tick on the last phase of an enabled run cycle.
    always_comb begin
        tick = run && (phase == LAST);
    end

    // Phase register: zeroed by reset/restart, advances only while running.
    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            phase <= '0;
        end else if (run) begin
            if (phase == LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with load/clear, prescaler and
// free-run / one-shot modes. Optional capture register under
// MOD_COUNTER_CAPTURE_EN (adds ports cap / cap_val).
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 15,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             done
`ifdef MOD_COUNTER_CAPTURE_EN
    ,
    input  logic             cap,
    output logic [WIDTH-1:0] cap_val
`endif
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    state_t           state, state_n;
    logic [WIDTH-1:0] c_n;
    logic             tc_n;
    logic             tick;
    logic             at_term;

    ce_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    ((state == RUN) && en),
        .restart(clr || load),
        .tick   (tick)
    );

    assign at_term = up ? (c == MAXV) : (c == '0);

    // State register plus registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            c     <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            c     <= c_n;
            tc    <= tc_n;
            done  <= (state_n == DONE);
        end
    end

    // Next-state logic; clr/load override the FSM and return it to IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (en) state_n = RUN;
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (tick && at_term && (mode == MODE_ONESHOT)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
        endcase
        if (clr || load) state_n = IDLE;
    end

    // Next count and terminal-count pulse, priority clr > load > tick.
    always_comb begin
        c_n  = c;
        tc_n = 1'b0;
        if (clr) begin
            c_n = '0;
        end else if (load) begin
            c_n = (load_val > MAXV) ? MAXV : load_val;
        end else if (tick) begin
            if (!at_term) begin
                c_n = up ? (c + WIDTH'(1)) : (c - WIDTH'(1));
            end else begin
                tc_n = 1'b1;
                if (mode == MODE_FREE) begin
                    c_n = up ? '0 : MAXV;
                end
            end
        end
    end

`ifdef MOD_COUNTER_CAPTURE_EN
    // Snapshot of the pre-edge count; independent of clr/load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_val <= '0;
        end else if (cap) begin
            cap_val <= c;
        end
    end
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MAX=9; PRESCALE 1 and 3).
module tb_mod_counter;

    typedef struct packed {
        logic [3:0] c;
        logic       tc;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, up, mode, clr, load, cap;
    logic [3:0] load_val;
    logic [3:0] c1, c3, capv1, capv3;
    logic       tc1, tc3, done1, done3;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .clr(clr),
        .load(load), .load_val(load_val), .c(c1), .tc(tc1), .done(done1)
`ifdef MOD_COUNTER_CAPTURE_EN
        , .cap(cap), .cap_val(capv1)
`endif
    );

    mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .mode(mode), .clr(clr),
        .load(load), .load_val(load_val), .c(c3), .tc(tc3), .done(done3)
`ifdef MOD_COUNTER_CAPTURE_EN
        , .cap(cap), .cap_val(capv3)
`endif
    );

`ifndef MOD_COUNTER_CAPTURE_EN
    assign capv1 = '0;
    assign capv3 = '0;
`endif

    // Advance one clock edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; en = 1'b1; up = 1'b1; mode = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = '0; cap = 1'b0;
        cyc();
        sb.push_back('{c: 4'd0, tc: 1'b0, done: 1'b0});
        cyc();
        e = sb.pop_front();
        checks++;
        if ({c1, tc1, done1, c3, tc3, done3, capv1} !== {e, e, 4'd0}) begin
            errors++;
            $display("FAIL reset: dut1 c=%0d tc=%b done=%b dut3 c=%0d tc=%b done=%b cap=%0d, required all 0",
                     c1, tc1, done1, c3, tc3, done3, capv1);
        end
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_free_up();
        exp_t e;
        en = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        up = 1'b1; mode = 1'b0; en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sb.push_back('{c: 4'(k % 10), tc: (k == 10), done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL free_up[%0d]: c=%0d tc=%b done=%b, required c=%0d tc=%b done=%b",
                         k, c1, tc1, done1, e.c, e.tc, e.done);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_free_down();
        exp_t e;
        logic [3:0] ec [7] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        en = 1'b0; up = 1'b0; mode = 1'b0;
        load = 1'b1; load_val = 4'd3;
        for (int k = 0; k < 7; k++) begin
            if (k == 1) begin
                load = 1'b0; en = 1'b1;
            end
            sb.push_back('{c: ec[k], tc: (k == 5), done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL free_down[%0d]: c=%0d tc=%b, required c=%0d tc=%b",
                         k, c1, tc1, e.c, e.tc);
            end
        end
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_load_clamp();
        exp_t e;
        logic [3:0] lv [4] = '{4'd12, 4'd5, 4'd9, 4'd15};
        logic [3:0] ec [4] = '{4'd9, 4'd5, 4'd9, 4'd9};
        en = 1'b0; load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            load_val = lv[k];
            sb.push_back('{c: ec[k], tc: 1'b0, done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL load_clamp[%0d]: c=%0d, required c=%0d", k, c1, e.c);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_prescale();
        exp_t e;
        logic       ep [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [3:0] ec [13] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3};
        en = 1'b0; up = 1'b1; mode = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        for (int k = 0; k < 13; k++) begin
            en = ep[k];
            sb.push_back('{c: ec[k], tc: 1'b0, done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c3, tc3, done3} !== e) begin
                errors++;
                $display("FAIL prescale[%0d]: c=%0d tc=%b, required c=%0d tc=%b",
                         k, c3, tc3, e.c, e.tc);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        exp_t e;
        logic [3:0] ec [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9, 9, 0, 0, 0, 1};
        en = 1'b0; up = 1'b1; clr = 1'b1; cyc(); clr = 1'b0;
        mode = 1'b1;
        for (int k = 0; k < 18; k++) begin
            en  = !(k == 12 || k == 14 || k == 15);
            clr = (k == 14);
            sb.push_back('{c: ec[k], tc: (k == 10), done: (k >= 10 && k <= 13)});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL oneshot[%0d]: c=%0d tc=%b done=%b, required c=%0d tc=%b done=%b",
                         k, c1, tc1, done1, e.c, e.tc, e.done);
            end
        end
        clr = 1'b0; en = 1'b0; mode = 1'b0;
    endtask

    task automatic test_load_on_wrap();
        exp_t e;
        logic [3:0] ec [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 4, 4, 5};
        en = 1'b0; up = 1'b1; mode = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        en = 1'b1; load_val = 4'd4;
        for (int k = 0; k < 13; k++) begin
            load = (k == 10);
            sb.push_back('{c: ec[k], tc: 1'b0, done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL load_on_wrap[%0d]: c=%0d tc=%b, required c=%0d tc=%b",
                         k, c1, tc1, e.c, e.tc);
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [3:0] ec [7] = '{0, 1, 2, 3, 0, 0, 1};
        en = 1'b0; up = 1'b1; mode = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rst_n = (k != 4);
            sb.push_back('{c: ec[k], tc: 1'b0, done: 1'b0});
            cyc();
            e = sb.pop_front();
            checks++;
            if ({c1, tc1, done1} !== e) begin
                errors++;
                $display("FAIL reset_mid[%0d]: c=%0d tc=%b done=%b, required c=%0d tc=%b done=%b",
                         k, c1, tc1, done1, e.c, e.tc, e.done);
            end
        end
        rst_n = 1'b1; en = 1'b0;
    endtask

`ifdef MOD_COUNTER_CAPTURE_EN
    task automatic test_capture();
        logic [3:0] ecap [3] = '{4'd5, 4'd5, 4'd5};
        en = 1'b0; up = 1'b1; mode = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        // c is 5 here; capture it, then clear and load to show cap_val holds.
        for (int k = 0; k < 3; k++) begin
            cap  = (k == 0);
            clr  = (k == 1);
            load = (k == 2);
            load_val = 4'd7;
            cyc();
            checks++;
            if (capv1 !== ecap[k]) begin
                errors++;
                $display("FAIL capture[%0d]: cap_val=%0d, required %0d", k, capv1, ecap[k]);
            end
        end
        cap = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_free_up();
        test_free_down();
        test_load_clamp();
        test_prescale();
        test_oneshot();
        test_load_on_wrap();
        test_reset_mid();
`ifdef MOD_COUNTER_CAPTURE_EN
        test_capture();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
